// File: rtl/vp_kbd_pkg.sv
// vp_kbd_pkg: key event type, PS/2 set-2 scancode to ascii map and gamepad numpad map
package vp_kbd_pkg;
  typedef struct packed {
    logic       released;
    logic [7:0] ascii;
  } kev_t;
  localparam logic [7:0] ASCII_NONE = 8'h00;
  // Entry k is the digit for numpad bit k: "1".."9" then "0"
  localparam logic [9:0][7:0] JOY_ASCII = {8'h30, 8'h39, 8'h38, 8'h37, 8'h36,
                                           8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
  function automatic logic [7:0] ps2_to_ascii(input logic [8:0] code);
    case (code)
      9'h016: return 8'h31;
      9'h01E: return 8'h32;
      9'h026: return 8'h33;
      9'h025: return 8'h34;
      9'h02E: return 8'h35;
      9'h036: return 8'h36;
      9'h03D: return 8'h37;
      9'h03E: return 8'h38;
      9'h046: return 8'h39;
      9'h045: return 8'h30;
      9'h01C: return 8'h61;
      9'h032: return 8'h62;
      9'h021: return 8'h63;
      9'h023: return 8'h64;
      9'h024: return 8'h65;
      9'h02B: return 8'h66;
      9'h034: return 8'h67;
      9'h033: return 8'h68;
      9'h043: return 8'h69;
      9'h03B: return 8'h6A;
      9'h042: return 8'h6B;
      9'h04B: return 8'h6C;
      9'h03A: return 8'h6D;
      9'h031: return 8'h6E;
      9'h044: return 8'h6F;
      9'h04D: return 8'h70;
      9'h015: return 8'h71;
      9'h02D: return 8'h72;
      9'h01B: return 8'h73;
      9'h02C: return 8'h74;
      9'h03C: return 8'h75;
      9'h02A: return 8'h76;
      9'h01D: return 8'h77;
      9'h022: return 8'h78;
      9'h035: return 8'h79;
      9'h01A: return 8'h7A;
      9'h029: return 8'h20;
      9'h079: return 8'h2B;
      9'h04E, 9'h07B: return 8'h2D;
      9'h07C: return 8'h2A;
      9'h04A, 9'h14A: return 8'h2F;
      9'h055: return 8'h3D;
      9'h11F: return 8'h11;
      9'h127: return 8'h12;
      9'h05A, 9'h15A: return 8'd10;
      9'h066: return 8'd8;
      default: return ASCII_NONE;
    endcase
  endfunction
endpackage

// File: rtl/vp_kev_fifo.sv
// vp_kev_fifo: synchronous key event FIFO with pop-before-push and removal of the youngest entry
import vp_kbd_pkg::*;
module vp_kev_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   res_n_i,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_drop,
  input  kev_t                   i_wdata,
  output kev_t                   o_head,
  output kev_t                   o_youngest,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  kev_t            r_mem [DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic [AW-1:0]   w_yidx;
  assign w_yidx     = r_wptr[AW-1:0] - AW'(1);
  assign o_head     = r_mem[r_rptr[AW-1:0]];
  assign o_youngest = r_mem[w_yidx];
  assign o_empty    = r_wptr == r_rptr;
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level    = r_wptr - r_rptr;
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= i_push ? r_wptr + (AW+1)'(1) : i_drop ? r_wptr - (AW+1)'(1) : r_wptr;
      if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/vp_key_event_queue.sv
// vp_key_event_queue: merges PS/2 and gamepad numpad key events into one ordered,
// buffered stream presented to vp_keymap over its ready/read handshake
import vp_kbd_pkg::*;
module vp_key_event_queue #(
  parameter int DEPTH    = 4,
  parameter int JOY_KEYS = 10
) (
  input  logic                   clk_i,
  input  logic                   res_n_i,
  input  logic [10:0]            ps2_key_i,
  input  logic [JOY_KEYS-1:0]    joy_numpad_i,
  output logic                   rx_data_ready_o,
  output logic [7:0]             rx_ascii_o,
  output logic                   rx_released_o,
  input  logic                   rx_read_i,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int JW = $clog2(JOY_KEYS);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_PRESENT = 2'd1, ST_GAP = 2'd2;
  logic                r_armed, r_prev_toggle;
  logic [JOY_KEYS-1:0] r_prev_joy, r_pend;
  logic [1:0]          r_state;
  kev_t                r_out;
  logic [JOY_KEYS-1:0] w_pend_all, w_joy_oh;
  logic [JW-1:0]       w_joy_idx;
  logic                w_joy_hit, w_ps2_valid, w_evt_valid;
  logic                w_push, w_pop, w_cancel, w_full, w_empty;
  logic [7:0]          w_ps2_ascii;
  kev_t                w_evt, w_head, w_youngest;
  assign w_ps2_ascii = ps2_to_ascii(ps2_key_i[8:0]);
  assign w_ps2_valid = r_armed && (ps2_key_i[10] != r_prev_toggle) && (w_ps2_ascii != ASCII_NONE);
  assign w_pend_all  = r_pend | (r_armed ? joy_numpad_i ^ r_prev_joy : '0);
  // Lowest pending numpad bit wins; the descending scan leaves it last
  always_comb begin
    w_joy_hit = 1'b0;
    w_joy_idx = '0;
    for (int k = JOY_KEYS - 1; k >= 0; k--) begin
      if (w_pend_all[k]) begin
        w_joy_hit = 1'b1;
        w_joy_idx = JW'(k);
      end
    end
  end
  assign w_joy_oh    = JOY_KEYS'(1) << w_joy_idx;
  assign w_evt       = w_ps2_valid ? kev_t'({~ps2_key_i[9], w_ps2_ascii})
                                   : kev_t'({~joy_numpad_i[w_joy_idx], JOY_ASCII[w_joy_idx]});
  assign w_evt_valid = w_ps2_valid || w_joy_hit;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  // A release that matches a still-queued press annihilates it instead of overflowing
  assign w_cancel    = w_evt_valid && w_full && !w_pop && w_evt.released &&
                       !w_youngest.released && (w_youngest.ascii == w_evt.ascii);
  assign w_push      = w_evt_valid && (!w_full || w_pop);
  assign overflow_o  = w_evt_valid && w_full && !w_pop && !w_cancel;
  assign rx_data_ready_o = r_state == ST_PRESENT;
  assign rx_ascii_o      = r_out.ascii;
  assign rx_released_o   = r_out.released;
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_armed       <= 1'b0;
      r_prev_toggle <= 1'b0;
      r_prev_joy    <= '0;
      r_pend        <= '0;
      r_state       <= ST_IDLE;
      r_out         <= '0;
    end else begin
      r_armed       <= 1'b1;
      r_prev_toggle <= ps2_key_i[10];
      r_prev_joy    <= joy_numpad_i;
      r_pend        <= w_pend_all & ~((w_joy_hit && !w_ps2_valid) ? w_joy_oh : '0);
      r_state       <= (r_state == ST_IDLE && !w_empty)      ? ST_PRESENT :
                       (r_state == ST_PRESENT && rx_read_i) ? ST_GAP :
                       (r_state == ST_GAP)                  ? ST_IDLE : r_state;
      if (w_pop) r_out <= w_head;
    end
  end
  vp_kev_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .res_n_i    (res_n_i),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_drop     (w_cancel),
    .i_wdata    (w_evt),
    .o_head     (w_head),
    .o_youngest (w_youngest),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (level_o)
  );
endmodule

// File: tb/tb_vp_key_event_queue.sv
// tb_vp_key_event_queue: scoreboard bench; expected events are queued as stimulus is
// driven and compared in order as the DUT presents them
module tb_vp_key_event_queue;
  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [9:0]  joy = '0;
  logic        rx_read = 1'b0;
  logic        rx_ready, rx_released, overflow;
  logic [7:0]  rx_ascii;
  logic [2:0]  level;
  logic        tog = 1'b0;
  logic        mon_prev = 1'b0;
  logic [8:0]  q[$];
  int          n_vec = 0;
  int          n_err = 0;

  vp_key_event_queue #(.DEPTH(4), .JOY_KEYS(10)) dut (
    .clk_i           (clk),
    .res_n_i         (res_n),
    .ps2_key_i       (ps2_key),
    .joy_numpad_i    (joy),
    .rx_data_ready_o (rx_ready),
    .rx_ascii_o      (rx_ascii),
    .rx_released_o   (rx_released),
    .rx_read_i       (rx_read),
    .overflow_o      (overflow),
    .level_o         (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ps2(input logic pressed, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (q.size() != 0 && c < maxc) begin
      @(negedge clk);
      rx_read = rx_ready;
      c++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      rx_read = rx_ready;
    end
    rx_read = 1'b0;
  endtask

  // Scoreboard: every rising rx_data_ready_o must match the oldest expected event
  initial begin
    forever begin
      @(negedge clk);
      if (rx_ready && !mon_prev) begin
        chk("evt_expected", q.size() != 0, 1);
        if (q.size() != 0) chk("evt", {23'b0, rx_released, rx_ascii}, {23'b0, q.pop_front()});
      end
      mon_prev = rx_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_ascii", rx_ascii, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    res_n = 1'b1;
    tick();
    tick();

    // 1: PS/2 press "1", latency and handshake
    tick();
    ps2(1'b1, 9'h016);
    q.push_back({1'b0, 8'h31});
    @(negedge clk);
    chk("t1_ready_n0", rx_ready, 0);
    chk("t1_level_n0", level, 0);
    @(negedge clk);
    chk("t1_ready_n1", rx_ready, 0);
    chk("t1_level_n1", level, 1);
    @(negedge clk);
    chk("t1_ready_n2", rx_ready, 1);
    repeat (3) @(negedge clk);
    chk("t1_ready_hold", rx_ready, 1);
    chk("t1_ascii_hold", rx_ascii, 8'h31);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    chk("t1_gap", rx_ready, 0);
    @(negedge clk);
    chk("t1_idle", rx_ready, 0);
    chk("t1_q_empty", q.size(), 0);

    // 2: joystick serializer ordering
    tick();
    joy = 10'b0000000101;
    q.push_back({1'b0, 8'h31});
    q.push_back({1'b0, 8'h33});
    drain(40);
    tick();
    joy = '0;
    q.push_back({1'b1, 8'h31});
    q.push_back({1'b1, 8'h33});
    drain(40);

    // 3: fill output register + FIFO, overflow, then cancel of youngest press
    tick();
    ps2(1'b1, 9'h016);
    q.push_back({1'b0, 8'h31});
    tick();
    ps2(1'b1, 9'h01C);
    q.push_back({1'b0, 8'h61});
    tick();
    ps2(1'b1, 9'h032);
    q.push_back({1'b0, 8'h62});
    tick();
    ps2(1'b1, 9'h021);
    q.push_back({1'b0, 8'h63});
    tick();
    ps2(1'b1, 9'h023);
    @(negedge clk);
    chk("t3_no_ovf_d", overflow, 0);
    tick();
    ps2(1'b1, 9'h024);
    @(negedge clk);
    chk("t3_ovf_e", overflow, 1);
    chk("t3_level_full", level, 4);
    chk("t3_ready", rx_ready, 1);
    tick();
    ps2(1'b0, 9'h023);
    @(negedge clk);
    chk("t3_no_ovf_cancel", overflow, 0);
    @(negedge clk);
    chk("t3_level_cancel", level, 3);
    chk("t3_ovf_idle", overflow, 0);
    drain(80);

    // 4: simultaneous PS/2 and joystick, PS/2 first
    tick();
    ps2(1'b1, 9'h015);
    joy = 10'b0000010000;
    q.push_back({1'b0, 8'h71});
    q.push_back({1'b0, 8'h35});
    drain(40);
    tick();
    joy = '0;
    q.push_back({1'b1, 8'h35});
    drain(40);

    // 5: reset during PRESENT with toggle=1 and joy bit0 held
    if (tog) begin
      tick();
      ps2(1'b0, 9'h076);
    end
    tick();
    ps2(1'b1, 9'h01E);
    joy = 10'b0000000001;
    q.push_back({1'b0, 8'h32});
    q.push_back({1'b0, 8'h31});
    begin
      int c = 0;
      while (!rx_ready && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    chk("t5_present", rx_ready, 1);
    res_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("t5_rst_ready", rx_ready, 0);
    chk("t5_rst_ascii", rx_ascii, 0);
    chk("t5_rst_rel", rx_released, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_ovf", overflow, 0);
    @(negedge clk);
    res_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_no_evt_ready", rx_ready, 0);
    chk("t5_no_evt_level", level, 0);
    tick();
    joy = '0;
    q.push_back({1'b1, 8'h31});
    drain(40);

    // 6: unmapped scancode is discarded silently
    tick();
    ps2(1'b1, 9'h076);
    @(negedge clk);
    chk("t6_ovf", overflow, 0);
    @(negedge clk);
    chk("t6_level", level, 0);
    @(negedge clk);
    chk("t6_ready", rx_ready, 0);
    repeat (3) @(negedge clk);
    chk("t6_q_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
